// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit followed by a STAGES-deep register pipeline.
// Extension happens combinationally into stage 1; later stages are plain copies.
module ext_pipe #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [OUT_W-1:0] din,
    input  logic [1:0]       addr_lo,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             align_err,
    output logic             busy
);

    localparam logic [2:0] OpZext = 3'd0;
    localparam logic [2:0] OpSext = 3'd1;
    localparam logic [2:0] OpUpper = 3'd2;
    localparam logic [2:0] OpLb = 3'd3;
    localparam logic [2:0] OpLbu = 3'd4;
    localparam logic [2:0] OpLh = 3'd5;
    localparam logic [2:0] OpLhu = 3'd6;
    localparam logic [2:0] OpWord = 3'd7;

    localparam int NumStg = int'(STAGES);

    logic [IN_W-1:0]  imm;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] err_q, err_d;
    logic [OUT_W-1:0]  data_q [STAGES];
    logic [OUT_W-1:0]  data_d [STAGES];

    assign imm      = din[IN_W-1:0];
    assign half_sel = addr_lo[1] ? din[31:16] : din[15:0];

    always_comb begin
        byte_sel = din[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = din[7:0];
            2'd1: byte_sel = din[15:8];
            2'd2: byte_sel = din[23:16];
            2'd3: byte_sel = din[31:24];
            default: byte_sel = din[7:0];
        endcase
    end

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        unique case (op)
            OpZext:  ext_data = {{(OUT_W-IN_W){1'b0}}, imm};
            OpSext:  ext_data = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            OpUpper: ext_data = {imm, {(OUT_W-IN_W){1'b0}}};
            OpLb:    ext_data = {{(OUT_W-8){byte_sel[7]}}, byte_sel};
            OpLbu:   ext_data = {{(OUT_W-8){1'b0}}, byte_sel};
            OpLh: begin
                ext_data = {{(OUT_W-16){half_sel[15]}}, half_sel};
                ext_err  = addr_lo[0];
            end
            OpLhu: begin
                ext_data = {{(OUT_W-16){1'b0}}, half_sel};
                ext_err  = addr_lo[0];
            end
            OpWord:  ext_data = din;
            default: ext_data = '0;
        endcase
    end

    // Flush beats stall; invalid stages always carry zero data and error.
    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
            err_d   = '0;
            for (int i = 0; i < NumStg; i++) begin
                data_d[i] = '0;
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            err_d[0]   = in_valid & ext_err;
            data_d[0]  = in_valid ? ext_data : '0;
            for (int i = 1; i < NumStg; i++) begin
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < NumStg; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < NumStg; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign dout      = out_valid ? data_q[STAGES-1] : '0;
    assign align_err = out_valid & err_q[STAGES-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized and directed checks of ext_pipe at depths 1, 2 and 4 against a
// delay-line reference model that computes extensions arithmetically.
module tb_ext_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] din;
    logic [1:0]  addr_lo;
    logic        stall;
    logic        flush;

    logic        ov   [3];
    logic [31:0] dout [3];
    logic        ae   [3];
    logic        bz   [3];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit        v;
        bit [31:0] d;
        bit        e;
    } slot_t;

    slot_t pipe [3][4];
    int    depth [3] = '{1, 2, 4};

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u_dut_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .din(din),
        .addr_lo(addr_lo), .stall(stall), .flush(flush),
        .out_valid(ov[0]), .dout(dout[0]), .align_err(ae[0]), .busy(bz[0])
    );

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) u_dut_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .din(din),
        .addr_lo(addr_lo), .stall(stall), .flush(flush),
        .out_valid(ov[1]), .dout(dout[1]), .align_err(ae[1]), .busy(bz[1])
    );

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(4)) u_dut_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .din(din),
        .addr_lo(addr_lo), .stall(stall), .flush(flush),
        .out_valid(ov[2]), .dout(dout[2]), .align_err(ae[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {align_err, data}; sign extension done as (x ^ msb) - msb.
    function automatic bit [32:0] ref_ext(bit [2:0] o, bit [31:0] d, bit [1:0] a);
        bit [31:0] imm;
        bit [31:0] b;
        bit [31:0] h;
        int        ai;
        ai  = int'(a);
        imm = d & 32'h0000_FFFF;
        b   = (d >> (8 * ai)) & 32'h0000_00FF;
        h   = a[1] ? (d >> 16) : (d & 32'h0000_FFFF);
        case (o)
            3'd0: return {1'b0, imm};
            3'd1: return {1'b0, (imm ^ 32'h8000) - 32'h8000};
            3'd2: return {1'b0, imm << 16};
            3'd3: return {1'b0, (b ^ 32'h80) - 32'h80};
            3'd4: return {1'b0, b};
            3'd5: return {a[0], (h ^ 32'h8000) - 32'h8000};
            3'd6: return {a[0], h};
            default: return {1'b0, d};
        endcase
    endfunction

    task automatic model_update();
        bit [32:0] r;
        r = ref_ext(op, din, addr_lo);
        for (int k = 0; k < 3; k++) begin
            if (reset || flush) begin
                for (int i = 0; i < 4; i++) pipe[k][i] = '{1'b0, 32'h0, 1'b0};
            end else if (!stall) begin
                for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
                if (in_valid) pipe[k][0] = '{1'b1, r[31:0], r[32]};
                else          pipe[k][0] = '{1'b0, 32'h0, 1'b0};
            end
        end
    endtask

    task automatic check_all();
        slot_t s;
        bit    any;
        for (int k = 0; k < 3; k++) begin
            s   = pipe[k][depth[k]-1];
            any = 1'b0;
            for (int i = 0; i < depth[k]; i++) any |= pipe[k][i].v;
            check_eq($sformatf("s%0d_outputs", depth[k]),
                     {29'h0, bz[k], ov[k], ae[k], dout[k]},
                     {29'h0, any, s.v, s.v & s.e, s.v ? s.d : 32'h0});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(bit v, bit [2:0] o, bit [31:0] d, bit [1:0] a);
        in_valid = v;
        op       = o;
        din      = d;
        addr_lo  = a;
    endtask

    // Single op through the depth-2 instance, result compared to a fixed constant.
    task automatic issue_one(string tag, bit [2:0] o, bit [31:0] d, bit [1:0] a,
                             bit [31:0] exp, bit exp_err);
        set_in(1'b1, o, d, a);
        tick();
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        tick();
        check_eq(tag, {30'h0, ov[1], ae[1], dout[1]}, {30'h0, 1'b1, exp_err, exp});
    endtask

    int lat [3];

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) pipe[k][i] = '{1'b0, 32'h0, 1'b0};
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++)
            check_eq("reset_state", {60'h0, ov[k], ae[k], bz[k], |dout[k]}, 64'h0);

        // Immediate modes back-to-back
        set_in(1'b1, 3'd0, 32'hABCD_8001, 2'd0);
        tick();
        set_in(1'b1, 3'd1, 32'hABCD_8001, 2'd0);
        tick();
        check_eq("imm_zext", {32'h0, dout[1]}, {32'h0, 32'h0000_8001});
        set_in(1'b1, 3'd2, 32'hABCD_8001, 2'd0);
        tick();
        check_eq("imm_sext", {32'h0, dout[1]}, {32'h0, 32'hFFFF_8001});
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        tick();
        check_eq("imm_upper", {32'h0, dout[1]}, {32'h0, 32'h8001_0000});
        tick();

        // Loads
        issue_one("lb_a0", 3'd3, 32'h8A7F_C3E1, 2'd0, 32'hFFFF_FFE1, 1'b0);
        issue_one("lb_a1", 3'd3, 32'h8A7F_C3E1, 2'd1, 32'hFFFF_FFC3, 1'b0);
        issue_one("lb_a2", 3'd3, 32'h8A7F_C3E1, 2'd2, 32'h0000_007F, 1'b0);
        issue_one("lb_a3", 3'd3, 32'h8A7F_C3E1, 2'd3, 32'hFFFF_FF8A, 1'b0);
        issue_one("lbu_a3", 3'd4, 32'h8A7F_C3E1, 2'd3, 32'h0000_008A, 1'b0);
        issue_one("lh_a2", 3'd5, 32'h8A7F_C3E1, 2'd2, 32'hFFFF_8A7F, 1'b0);
        issue_one("lhu_a0", 3'd6, 32'h8A7F_C3E1, 2'd0, 32'h0000_C3E1, 1'b0);
        issue_one("lh_misalign", 3'd5, 32'h1234_5678, 2'd1, 32'h0000_5678, 1'b1);
        issue_one("word_pass", 3'd7, 32'hDEAD_BEEF, 2'd3, 32'hDEAD_BEEF, 1'b0);

        // Stall for two cycles after the first of three ops
        set_in(1'b1, 3'd7, 32'h1111_1111, 2'd0);
        tick();
        stall = 1'b1;
        set_in(1'b1, 3'd7, 32'h9999_9999, 2'd0);
        tick();
        tick();
        stall = 1'b0;
        set_in(1'b1, 3'd7, 32'h2222_2222, 2'd0);
        tick();
        set_in(1'b1, 3'd7, 32'h3333_3333, 2'd0);
        tick();
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        for (int c = 0; c < 5; c++) tick();

        // Flush plus stall with two ops in flight
        set_in(1'b1, 3'd1, 32'h0000_7FFF, 2'd0);
        tick();
        tick();
        flush = 1'b1;
        stall = 1'b1;
        set_in(1'b1, 3'd7, 32'h5555_AAAA, 2'd0);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        for (int k = 0; k < 3; k++)
            check_eq("flush_clears", {62'h0, ov[k], bz[k]}, 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 3; k++) check_eq("flush_drop", {63'h0, ov[k]}, 64'h0);
        end

        // Reset mid-stream
        set_in(1'b1, 3'd7, 32'hCAFE_0001, 2'd0);
        tick();
        tick();
        reset = 1'b1;
        set_in(1'b1, 3'd7, 32'hCAFE_0002, 2'd0);
        tick();
        reset = 1'b0;
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        for (int k = 0; k < 3; k++)
            check_eq("reset_mid", {29'h0, ov[k], ae[k], bz[k], dout[k]}, 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 3; k++) check_eq("reset_drop", {63'h0, ov[k]}, 64'h0);
        end

        // Latency sweep, bounded wait
        for (int k = 0; k < 3; k++) lat[k] = 0;
        set_in(1'b1, 3'd4, 32'h0000_00F0, 2'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            set_in(1'b0, 3'd0, 32'h0, 2'd0);
            for (int k = 0; k < 3; k++) if (ov[k] && lat[k] == 0) lat[k] = c;
        end
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("latency_s%0d", depth[k]), 64'(lat[k]), 64'(depth[k]));

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            set_in(($urandom % 10) < 7, 3'($urandom), $urandom, 2'($urandom));
            stall = ($urandom % 8) == 0;
            flush = ($urandom % 25) == 0;
            reset = ($urandom % 80) == 0;
            tick();
        end
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 3'd0, 32'h0, 2'd0);
        for (int c = 0; c < 6; c++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate field width.
REQ-002 SHALL have parameter OUT_W, default 32, result and load-word width; legal only as 32.
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth; legal 1..4.
REQ-004 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have in_valid, input, 1, operation present this cycle.
REQ-007 SHALL have op, input, 3, extension mode (see REQ-014).
REQ-008 SHALL have din, input, OUT_W, low IN_W bits for imm modes, full word for load modes.
REQ-009 SHALL have addr_lo, input, 2, byte offset for load modes.
REQ-010 SHALL have stall, input, 1, freeze all stages.
REQ-011 SHALL have flush, input, 1, invalidate all stages.
REQ-012 SHALL have out_valid, output, 1, result valid at final stage.
REQ-013 SHALL have dout (output, OUT_W, result), align_err (output, 1, misaligned halfword access flagged with result), and busy (output, 1, any stage valid).

Function
REQ-014 op encoding SHALL be: 0 zero-ext imm; 1 sign-ext imm; 2 imm placed in upper IN_W bits, lower bits zero; 3 lb (sign byte); 4 lbu; 5 lh (sign half); 6 lhu; 7 word pass-through.
REQ-015 Byte modes SHALL select din byte addr_lo (0 = bits 7:0, 3 = bits 31:24).
REQ-016 Half modes SHALL select bits 15:0 when addr_lo[1]=0, bits 31:16 when addr_lo[1]=1.
REQ-017 Half mode with addr_lo[0]=1 SHALL set align_err=1 and return the addr_lo[1]-selected half anyway; other modes SHALL give align_err=0.
REQ-018 Op 7 SHALL ignore addr_lo.
REQ-019 Extension SHALL be computed combinationally into stage 1; stages 2..STAGES SHALL be pure register copies.
REQ-020 Latency SHALL be exactly STAGES cycles from in_valid sampled high to out_valid high, absent stall.
REQ-021 Throughput SHALL be one op per cycle; back-to-back ops SHALL emerge in order, one per cycle.
REQ-022 stall=1 SHALL hold every stage's valid, data and align_err; in_valid during stall SHALL be dropped.
REQ-023 flush=1 SHALL clear every stage valid next edge; in_valid in the same cycle SHALL be dropped.
REQ-024 flush SHALL take priority over stall; reset SHALL take priority over both.
REQ-025 When out_valid=0, dout and align_err SHALL be 0.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 An invalid stage SHALL hold zeroed data, so bubbles never expose stale values.

Reset
REQ-028 reset=1 at a clock edge SHALL clear all stage valid bits, data and align_err to 0; out_valid, dout, align_err and busy SHALL read 0 the following cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight ops; no op accepted in the reset cycle SHALL emerge.

Verification
REQ-030 Imm modes, STAGES=2: din low 16 = 0x8001, op 0/1/2 on consecutive cycles -> dout 0x00008001, 0xFFFF8001, 0x80010000 on cycles 2, 3, 4 after the first op.
REQ-031 Loads: din=0x8A7F_C3E1; op3 with addr_lo=0..3 -> 0xFFFFFFE1, 0xFFFFFFC3, 0x0000007F, 0xFFFFFF8A; op4 with addr_lo=3 -> 0x0000008A; op5 with addr_lo=2 -> 0xFFFF8A7F; op6 with addr_lo=0 -> 0x0000C3E1.
REQ-032 Misalign: op5, addr_lo=1, din=0x1234_5678 -> dout=0x00005678 with align_err=1 alongside out_valid.
REQ-033 Stall: 3 back-to-back ops, stall high for 2 cycles after the first -> outputs frozen 2 cycles, all 3 emerge in order, none lost or duplicated.
REQ-034 Flush plus stall in the same cycle with 2 ops in flight -> out_valid and busy 0 next cycle; op offered that cycle never emerges.
REQ-035 Reset mid-stream, and STAGES=1 vs 4 sweep -> all outputs 0 after reset; latency equals STAGES.
